// File: rtl/issue_scheduler.sv
// issue_scheduler
//   Round-robin issue arbiter for NUM_RS reservation stations, each feeding its
//   own pipelined FU of fixed latency. A shift register of completion slots
//   tracks which future cycle already owns the shared result bus. A station may
//   only issue when its completion would land on a free cycle.
//
// Ports
//   clk         clock
//   reset       synchronous active-high reset (clears slots and pointer)
//   flush       drops all pending completions, blocks issue this cycle
//   rs_ready    per-station insn_ready
//   rs_dst_tag  per-station destination ROB tag, slice i = station i
//   issue       one-hot-or-zero issue command
//   wakeup      completion broadcast valid (from slot 0)
//   wakeup_tag  ROB tag of the completing instruction, 0 when idle
//   wakeup_src  one-hot completing FU (result-mux select), 0 when idle
module issue_scheduler #(
    parameter int NUM_RS      = 4,
    parameter int MAX_LAT     = 4,
    parameter int LAT0        = 1,
    parameter int LAT1        = 1,
    parameter int LAT2        = 3,
    parameter int LAT3        = 4,
    parameter int ROB_TAG_LEN = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [NUM_RS-1:0]             rs_ready,
    input  logic [NUM_RS*ROB_TAG_LEN-1:0] rs_dst_tag,
    output logic [NUM_RS-1:0]             issue,
    output logic                          wakeup,
    output logic [ROB_TAG_LEN-1:0]        wakeup_tag,
    output logic [NUM_RS-1:0]             wakeup_src
);

    localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    function automatic int lat_of(input int i);
        case (i)
            0:       return LAT0;
            1:       return LAT1;
            2:       return LAT2;
            default: return LAT3;
        endcase
    endfunction

    // s[k] completes k cycles after the current one
    logic [MAX_LAT-1:0]                  slot_valid;
    logic [MAX_LAT-1:0][ROB_TAG_LEN-1:0] slot_tag;
    logic [MAX_LAT-1:0][NUM_RS-1:0]      slot_src;
    logic [PTR_W-1:0]                    ptr;

    logic [NUM_RS-1:0] eligible;
    logic [NUM_RS-1:0] grant;
    logic [PTR_W-1:0]  ptr_next;

    // A latency-L issue is written to s[L-1] after the shift, so it collides
    // with whatever currently sits in s[L]. Max-latency stations never collide.
    for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_elig
        localparam int L = lat_of(gi);
        logic blocked;
        if (L >= MAX_LAT) begin : g_free
            assign blocked = 1'b0;
        end else begin : g_chk
            assign blocked = slot_valid[L];
        end
        assign eligible[gi] = rs_ready[gi] & ~blocked & ~flush & ~reset;
    end

    // Rotating-priority search starting at ptr; first eligible station wins.
    always_comb begin
        int unsigned cand;
        logic        found;
        grant    = '0;
        ptr_next = ptr;
        cand     = 0;
        found    = 1'b0;
        for (int unsigned n = 0; n < NUM_RS; n++) begin
            cand = 32'(ptr) + n;
            if (cand >= NUM_RS) begin
                cand = cand - NUM_RS;
            end
            for (int unsigned i = 0; i < NUM_RS; i++) begin
                if (!found && i == cand && eligible[i]) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                    ptr_next = (i == NUM_RS - 1) ? '0 : PTR_W'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= '0;
            slot_tag   <= '0;
            slot_src   <= '0;
            ptr        <= '0;
        end else if (flush) begin
            slot_valid <= '0;
            slot_tag   <= '0;
            slot_src   <= '0;
        end else begin
            for (int unsigned k = 0; k + 1 < MAX_LAT; k++) begin
                slot_valid[k] <= slot_valid[k+1];
                slot_tag[k]   <= slot_tag[k+1];
                slot_src[k]   <= slot_src[k+1];
            end
            slot_valid[MAX_LAT-1] <= 1'b0;
            slot_tag[MAX_LAT-1]   <= '0;
            slot_src[MAX_LAT-1]   <= '0;
            // Eligibility guarantees the shifted-in value here is invalid.
            for (int unsigned i = 0; i < NUM_RS; i++) begin
                if (grant[i]) begin
                    slot_valid[lat_of(i)-1] <= 1'b1;
                    slot_tag[lat_of(i)-1]   <= rs_dst_tag[i*ROB_TAG_LEN +: ROB_TAG_LEN];
                    slot_src[lat_of(i)-1]   <= NUM_RS'(1) << i;
                end
            end
            ptr <= ptr_next;
        end
    end

    assign issue      = grant;
    assign wakeup     = slot_valid[0];
    assign wakeup_tag = slot_valid[0] ? slot_tag[0] : '0;
    assign wakeup_src = slot_valid[0] ? slot_src[0] : '0;

endmodule

// File: tb/tb_issue_scheduler.sv
// Testbench for issue_scheduler.
// The reference model tracks pending completions by absolute due cycle and a
// round-robin pointer; a second instance with LAT1=4 exercises the
// blocked-station skip with hand-derived expectations.
module tb_issue_scheduler;

    localparam int NRS     = 4;
    localparam int MAXL    = 4;
    localparam int TW      = 6;
    localparam int LATS [NRS] = '{1, 1, 3, 4};

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic [NRS-1:0]    rs_ready;
    logic [NRS*TW-1:0] rs_dst_tag;

    logic [NRS-1:0]    issue, issue_b;
    logic              wakeup, wakeup_b;
    logic [TW-1:0]     wakeup_tag, wakeup_tag_b;
    logic [NRS-1:0]    wakeup_src, wakeup_src_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    issue_scheduler #(
        .NUM_RS(NRS), .MAX_LAT(MAXL), .LAT0(1), .LAT1(1), .LAT2(3), .LAT3(4),
        .ROB_TAG_LEN(TW)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .rs_ready(rs_ready),
        .rs_dst_tag(rs_dst_tag), .issue(issue), .wakeup(wakeup),
        .wakeup_tag(wakeup_tag), .wakeup_src(wakeup_src)
    );

    issue_scheduler #(
        .NUM_RS(NRS), .MAX_LAT(MAXL), .LAT0(1), .LAT1(4), .LAT2(3), .LAT3(4),
        .ROB_TAG_LEN(TW)
    ) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .rs_ready(rs_ready),
        .rs_dst_tag(rs_dst_tag), .issue(issue_b), .wakeup(wakeup_b),
        .wakeup_tag(wakeup_tag_b), .wakeup_src(wakeup_src_b)
    );

    // ---------------- reference model ----------------
    int             cyc  = 0;
    int             mptr = 0;
    logic [TW-1:0]  due_tag [int];
    logic [NRS-1:0] due_src [int];

    logic [NRS-1:0] exp_issue;
    logic           exp_wk;
    logic [TW-1:0]  exp_tag;
    logic [NRS-1:0] exp_src;
    int             exp_g;
    logic [14:0]    obs, want;

    task automatic model_predict();
        exp_issue = '0;
        exp_g     = -1;
        if (!reset && !flush) begin
            for (int n = 0; n < NRS; n++) begin
                int i;
                i = (mptr + n) % NRS;
                if (exp_g < 0 && rs_ready[i] &&
                    (LATS[i] == MAXL || !due_tag.exists(cyc + LATS[i]))) begin
                    exp_g        = i;
                    exp_issue[i] = 1'b1;
                end
            end
        end
        exp_wk  = due_tag.exists(cyc);
        exp_tag = exp_wk ? due_tag[cyc] : '0;
        exp_src = exp_wk ? due_src[cyc] : '0;
        want    = {exp_issue, exp_wk, exp_tag, exp_src};
        obs     = {issue, wakeup, wakeup_tag, wakeup_src};
    endtask

    task automatic model_commit();
        if (reset || flush) begin
            due_tag.delete();
            due_src.delete();
            if (reset) mptr = 0;
        end else begin
            if (due_tag.exists(cyc)) begin
                due_tag.delete(cyc);
                due_src.delete(cyc);
            end
            if (exp_g >= 0) begin
                due_tag[cyc + LATS[exp_g]] = rs_dst_tag[exp_g*TW +: TW];
                due_src[cyc + LATS[exp_g]] = 4'b0001 << exp_g;
                mptr = (exp_g + 1) % NRS;
            end
        end
        cyc++;
    endtask

    function automatic logic [NRS*TW-1:0] rand_tags();
        logic [NRS*TW-1:0] t;
        for (int i = 0; i < NRS; i++) begin
            t[i*TW +: TW] = {4'($urandom), 2'(i)};
        end
        return t;
    endfunction

    // Apply inputs just after a rising edge, settle to the falling edge, predict.
    task automatic drive(input logic [NRS-1:0] rdy, input logic fl, input logic rst,
                         input logic [NRS*TW-1:0] tags);
        rs_ready   = rdy;
        flush      = fl;
        reset      = rst;
        rs_dst_tag = tags;
        @(negedge clk);
        model_predict();
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(4'hF, 1'b0, 1'b1, rand_tags());
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(4'($urandom), 1'($urandom), 1'b1, rand_tags());
            checks++;
            if (obs !== want || obs !== 15'h0) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%h want=%h", cyc, obs, want);
            end
            tick();
        end
    endtask

    task automatic test_single();
        logic [NRS*TW-1:0] t;
        drive(4'h0, 1'b0, 1'b1, rand_tags());
        tick();
        t = rand_tags();
        t[TW-1:0] = 6'd5;
        for (int k = 0; k < 3; k++) begin
            drive((k == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, t);
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL single cyc=%0d got=%h want=%h", cyc, obs, want);
            end
            if (k == 1) begin
                checks++;
                if ({wakeup, wakeup_tag, wakeup_src} !== {1'b1, 6'd5, 4'b0001}) begin
                    failures++;
                    $display("FAIL single_wakeup got=%b/%0d/%b want=1/5/0001",
                             wakeup, wakeup_tag, wakeup_src);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        drive(4'h0, 1'b0, 1'b1, rand_tags());
        tick();
        for (int k = 0; k < 20; k++) begin
            drive(4'hF, 1'b0, 1'b0, rand_tags());
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL round_robin cyc=%0d got=%h want=%h", cyc, obs, want);
            end
            tick();
        end
    endtask

    task automatic test_blocked();
        logic [3:0] seq [7] = '{4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        drive(4'h0, 1'b0, 1'b1, rand_tags());
        tick();
        for (int k = 0; k < 7; k++) begin
            drive(seq[k], 1'b0, 1'b0, rand_tags());
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL blocked cyc=%0d got=%h want=%h", cyc, obs, want);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        logic [3:0] seq [6] = '{4'b0100, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        logic       fls [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        drive(4'h0, 1'b0, 1'b1, rand_tags());
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(seq[k], fls[k], 1'b0, rand_tags());
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL flush cyc=%0d got=%h want=%h", cyc, obs, want);
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        logic [3:0] seq [7] = '{4'b1000, 4'b0101, 4'b1111, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        logic       rst [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        drive(4'h0, 1'b0, 1'b1, rand_tags());
        tick();
        for (int k = 0; k < 7; k++) begin
            drive(seq[k], 1'b0, rst[k], rand_tags());
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL reset_mid cyc=%0d got=%h want=%h", cyc, obs, want);
            end
            tick();
        end
    endtask

    // dut_b: LAT = 1,4,3,4. RS1 issues (ptr->2); next cycle RS2 is blocked by
    // RS1's completion in s[3], so RS3 wins and ptr wraps to 0.
    task automatic test_skip_blocked();
        logic [3:0] seq  [7] = '{4'b0010, 4'b1100, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] eiss [7] = '{4'b0010, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] esrc [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b1000, 4'b0000};
        drive(4'h0, 1'b0, 1'b1, rand_tags());
        tick();
        for (int k = 0; k < 7; k++) begin
            drive(seq[k], 1'b0, 1'b0, rand_tags());
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL skip_main cyc=%0d got=%h want=%h", cyc, obs, want);
            end
            checks++;
            if ({issue_b, wakeup_b, wakeup_src_b} !== {eiss[k], esrc[k] != 4'b0000, esrc[k]}) begin
                failures++;
                $display("FAIL skip_blocked step=%0d got issue=%b wk=%b src=%b want issue=%b src=%b",
                         k, issue_b, wakeup_b, wakeup_src_b, eiss[k], esrc[k]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        drive(4'h0, 1'b0, 1'b1, rand_tags());
        tick();
        for (int k = 0; k < 400; k++) begin
            drive(4'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 49) == 0),
                  rand_tags());
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, want);
            end
            tick();
        end
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        rs_ready   = '0;
        rs_dst_tag = '0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_blocked();
        test_flush();
        test_reset_midflight();
        test_skip_blocked();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
